// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
`default_nettype none

package prefetch_pkg;

  localparam int unsigned XLEN    = 24;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// Entry FIFO for the prefetch buffer; each entry is {pc, word}, head visible combinationally.
`default_nettype none

module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int unsigned N     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [2*N-1:0]             wdata_i,
  output logic [2*N-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [2*N-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flush wins over any same-cycle push or pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: single-outstanding fetch FSM feeding an entry FIFO.
// Optional PREFETCH_STATS_EN adds saturating fetched/flushed counters.
`default_nettype none

module instr_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int unsigned N     = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic         imem_rvalid_i,
  input  logic [N-1:0] imem_rdata_i,
  output logic         instr_valid_o,
  output logic [N-1:0] instr_o,
  output logic [N-1:0] instr_pc_o,
  input  logic         instr_ready_i,
  input  logic         redirect_i,
  input  logic [N-1:0] redirect_addr_i
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]  stat_fetched_o,
  output logic [15:0]  stat_flushed_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e         state_q, state_d;
  logic [N-1:0]   fetch_pc_q, fetch_pc_d;
  logic [N-1:0]   req_pc_q, req_pc_d;
  logic           push, pop, stale_drop;
  logic [AW:0]    count;
  logic           full, empty;
  logic [2*N-1:0] rdata;

  prefetch_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .wdata_i ({req_pc_q, imem_rdata_i}),
    .rdata_o (rdata),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign instr_valid_o = rst && !empty;
  assign {instr_pc_o, instr_o} = rdata;
  assign pop = instr_valid_o && instr_ready_i && !redirect_i;
  assign imem_addr_o = imem_req_o ? fetch_pc_q : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    imem_req_o = 1'b0;
    push       = 1'b0;
    stale_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst && !redirect_i && (count < (AW+1)'(DEPTH))) begin
          imem_req_o = 1'b1;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + N'(PC_STEP);
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (imem_rvalid_i) begin
          state_d    = IDLE;
          stale_drop = redirect_i;
          push       = !redirect_i && !full;
        end else if (redirect_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_rvalid_i) begin
          state_d    = IDLE;
          stale_drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_i) fetch_pc_d = redirect_addr_i & ~N'(3);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetched_q, stat_flushed_q;
  logic [15:0] flush_inc;

  // Discarded entries on redirect plus one for any dropped stale response.
  assign flush_inc = (redirect_i ? 16'(count) : 16'd0) + {15'd0, stale_drop};

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= sat_add16(stat_fetched_q, {15'd0, push});
      stat_flushed_q <= sat_add16(stat_flushed_q, flush_inc);
    end
  end

  assign stat_fetched_o = stat_fetched_q;
  assign stat_flushed_o = stat_flushed_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized self-checking bench for instr_prefetch_buffer against a queue-based model.
`default_nettype none

module tb_instr_prefetch_buffer;

  localparam int N     = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_rvalid;
  logic [N-1:0]  imem_rdata;
  logic          instr_valid;
  logic [N-1:0]  instr;
  logic [N-1:0]  instr_pc;
  logic          instr_ready;
  logic          redirect;
  logic [N-1:0]  redirect_addr;
`ifdef PREFETCH_STATS_EN
  logic [15:0]   stat_fetched;
  logic [15:0]   stat_flushed;
`endif

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_o      (imem_req),
    .imem_addr_o     (imem_addr),
    .imem_rvalid_i   (imem_rvalid),
    .imem_rdata_i    (imem_rdata),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_ready_i   (instr_ready),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetched_o  (stat_fetched),
    .stat_flushed_o  (stat_flushed)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Stimulus controls
  logic          s_rst, s_ready, s_redirect, s_rvalid;
  logic [N-1:0]  s_raddr, s_rdata;
  bit            use_mem;
  int            mem_lat_max;

  // Memory responder
  bit            mem_pend;
  logic [N-1:0]  mem_addr;
  int            mem_delay;

  // Reference model: abstract queue plus one outstanding-request flag
  typedef struct {
    logic [N-1:0] pc;
    logic [N-1:0] word;
  } ent_t;
  ent_t          mq[$];
  logic [N-1:0]  m_pc, m_out_addr;
  bit            m_out, m_stale;
  int            m_fetched, m_flushed;

  // Observed outputs from the latest cycle
  logic          o_req, o_valid;
  logic [N-1:0]  o_addr, o_pc, o_instr;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic step();
    bit           e_req, e_valid;
    logic [N-1:0] e_addr;
    @(posedge clk);
    #1;
    rst           = s_rst;
    instr_ready   = s_ready;
    redirect      = s_redirect;
    redirect_addr = s_raddr;
    if (use_mem) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 24'($urandom);
      if (mem_pend) begin
        if (mem_delay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_addr + 24'h100000;
          mem_pend    = 1'b0;
        end else begin
          mem_delay--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        imem_rvalid = 1'b1;
      end
    end else begin
      imem_rvalid = s_rvalid;
      imem_rdata  = s_rdata;
    end
    #1;
    e_req   = s_rst && !m_out && (mq.size() < DEPTH) && !s_redirect;
    e_addr  = e_req ? m_pc : '0;
    e_valid = s_rst && (mq.size() > 0);
    cmp("imem_req", 32'(imem_req), 32'(e_req));
    cmp("imem_addr", 32'(imem_addr), 32'(e_addr));
    cmp("instr_valid", 32'(instr_valid), 32'(e_valid));
    if (e_valid) begin
      cmp("instr", 32'(instr), 32'(mq[0].word));
      cmp("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
    end
`ifdef PREFETCH_STATS_EN
    cmp("stat_fetched", 32'(stat_fetched), 32'(m_fetched));
    cmp("stat_flushed", 32'(stat_flushed), 32'(m_flushed));
`endif
    o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid;
    o_pc = instr_pc;  o_instr = instr;
    if (use_mem && imem_req === 1'b1) begin
      mem_pend  = 1'b1;
      mem_addr  = imem_addr;
      mem_delay = $urandom_range(0, mem_lat_max);
    end
    // Advance the model to the state after this clock edge
    if (!s_rst) begin
      mq.delete();
      m_pc = '0; m_out = 0; m_stale = 0; m_fetched = 0; m_flushed = 0;
    end else if (s_redirect) begin
      m_flushed = sat16(m_flushed + mq.size());
      if (m_out) begin
        if (imem_rvalid) begin
          m_flushed = sat16(m_flushed + 1);
          m_out = 0; m_stale = 0;
        end else begin
          m_stale = 1;
        end
      end
      mq.delete();
      m_pc = s_raddr & 24'hFFFFFC;
    end else begin
      if (mq.size() > 0 && s_ready) void'(mq.pop_front());
      if (m_out && imem_rvalid) begin
        if (m_stale) m_flushed = sat16(m_flushed + 1);
        else begin
          mq.push_back('{pc: m_out_addr, word: imem_rdata});
          m_fetched = sat16(m_fetched + 1);
        end
        m_out = 0; m_stale = 0;
      end else if (e_req) begin
        m_out = 1; m_out_addr = m_pc; m_pc = m_pc + 24'd4;
      end
    end
  endtask

  task automatic do_reset();
    s_rst = 0; s_redirect = 0; s_rvalid = 0; s_ready = 0;
    mem_pend = 0;
    step(); step();
    s_rst = 1;
  endtask

  initial begin
    int nreq;
    rst = 0; instr_ready = 0; redirect = 0; redirect_addr = '0;
    imem_rvalid = 0; imem_rdata = '0;
    s_raddr = '0; s_rdata = '0;
    use_mem = 1; mem_lat_max = 0;
    mem_pend = 0; mem_addr = '0; mem_delay = 0;
    m_pc = '0; m_out_addr = '0; m_out = 0; m_stale = 0; m_fetched = 0; m_flushed = 0;

    // Streaming fetch with 1-cycle memory and ready consumer
    do_reset();
    s_ready = 1;
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 0) cmp("reset_first_req", 32'(o_req), 32'd1);
      if (o_req) begin
        cmp("stream_addr", 32'(o_addr), 32'(4 * nreq));
        nreq++;
      end
    end
    cmp("stream_nreq", 32'(nreq), 32'd7);

    // Stalled consumer: exactly DEPTH requests, then one more only after a pop
    do_reset();
    s_ready = 0;
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_req) begin
        nreq++;
        cmp("stall_addr", 32'(o_addr), 32'(4 * (nreq - 1)));
      end
    end
    cmp("stall_nreq", 32'(nreq), 32'd4);
    cmp("stall_valid", 32'(o_valid), 32'd1);
    s_ready = 1; step();
    cmp("stall_pop_noreq", 32'(o_req), 32'd0);
    s_ready = 0; step();
    cmp("stall_next_req", 32'(o_req), 32'd1);
    cmp("stall_next_addr", 32'(o_addr), 32'h10);

    // Redirect while a request is outstanding, stale response 2 cycles later
    use_mem = 0;
    do_reset();
    step();
    cmp("flush_req0", 32'(o_addr), 32'h0);
    s_redirect = 1; s_raddr = 24'h000123; step();
    cmp("flush_redir_noreq", 32'(o_req), 32'd0);
    s_redirect = 0; step();
    cmp("flush_wait_noreq", 32'(o_req), 32'd0);
    cmp("flush_wait_empty", 32'(o_valid), 32'd0);
    s_rvalid = 1; s_rdata = 24'hABCDEF; step();
    cmp("flush_drop_noreq", 32'(o_req), 32'd0);
    s_rvalid = 0; step();
    cmp("flush_resume_req", 32'(o_req), 32'd1);
    cmp("flush_resume_addr", 32'(o_addr), 32'h000120);
    cmp("flush_resume_empty", 32'(o_valid), 32'd0);

    // Redirect coincident with response and pop
    do_reset();
    step();
    s_rvalid = 1; s_rdata = 24'h111111; step();
    s_rvalid = 0; step();
    cmp("coinc_valid", 32'(o_valid), 32'd1);
    cmp("coinc_pc", 32'(o_pc), 32'h0);
    cmp("coinc_word", 32'(o_instr), 32'h111111);
    s_redirect = 1; s_raddr = 24'h000040; s_rvalid = 1; s_rdata = 24'h222222; s_ready = 1; step();
    s_redirect = 0; s_rvalid = 0; s_ready = 0; step();
    cmp("coinc_empty", 32'(o_valid), 32'd0);
    cmp("coinc_req_addr", 32'(o_addr), 32'h000040);

    // Fetch PC wrap-around
    do_reset();
    s_redirect = 1; s_raddr = 24'hFFFFFF; step();
    cmp("wrap_redir_noreq", 32'(o_req), 32'd0);
    s_redirect = 0; step();
    cmp("wrap_addr_hi", 32'(o_addr), 32'hFFFFFC);
    s_rvalid = 1; s_rdata = 24'h333333; step();
    s_rvalid = 0; step();
    cmp("wrap_addr_lo", 32'(o_addr), 32'h000000);
    cmp("wrap_head_pc", 32'(o_pc), 32'hFFFFFC);

`ifdef PREFETCH_STATS_EN
    // Three fetches buffered, fourth outstanding, then redirect
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step();
      s_rvalid = 1; s_rdata = 24'(k); step();
      s_rvalid = 0;
    end
    step();
    cmp("stats_req_c", 32'(o_addr), 32'h00000C);
    s_redirect = 1; s_raddr = 24'h000200; step();
    s_redirect = 0; s_rvalid = 1; step();
    s_rvalid = 0; step();
    cmp("stats_fetched", 32'(stat_fetched), 32'd3);
    cmp("stats_flushed", 32'(stat_flushed), 32'd4);
`endif

    // Randomized traffic with variable memory latency, redirects and resets
    use_mem = 1; mem_lat_max = 3;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      s_rst      = ($urandom_range(0, 199) != 0);
      s_ready    = ($urandom_range(0, 3) != 0);
      s_redirect = ($urandom_range(0, 19) == 0);
      s_raddr    = ($urandom_range(0, 7) == 0) ? 24'hFFFFF8 + 24'($urandom_range(0, 7))
                                                : 24'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
